// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/imem_loader_asm.sv
// MSB-first byte-to-word shift assembler, shared by header count and data words.
module byte_word_asm
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] data_byte,
  output logic [WORD_W-1:0] word_c,
  output logic              last_c
);

  localparam int unsigned CNT_W = $clog2(WORD_BYTES);
  localparam int unsigned SR_W  = WORD_W - BYTE_W;

  logic [CNT_W-1:0] cnt_q;
  logic [SR_W-1:0]  sr_q;

  // Word as it stands once the byte on the input is shifted in.
  assign word_c = {sr_q, data_byte};
  assign last_c = (cnt_q == CNT_W'(WORD_BYTES - 1));

  // Byte counter wraps naturally after the last byte of a word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (shift_en) begin
      cnt_q <= cnt_q + CNT_W'(1);
      sr_q  <= word_c[SR_W-1:0];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a framed byte stream and releases the core on success.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_ldr_i,
  input  logic [7:0]  byte_ldr_i,
  input  logic        byte_valid_ldr_i,
  output logic        byte_ready_ldr_o,
  output logic [31:0] wr_addr_imem_ldr_o,
  output logic [31:0] wr_instr_imem_ldr_o,
  output logic        wr_en_imem_ldr_o,
  output logic        cpu_reset_ldr_o,
  output logic        busy_ldr_o,
  output logic        done_ldr_o,
  output logic        err_ldr_o
);

  localparam int unsigned CNT_W = HDR_BYTES * BYTE_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q;
  logic [WORD_W-1:0]   word_idx_q;
  logic [WORD_W-1:0]   word_idx_inc_c;
  logic [BYTE_W-1:0]   xor_q;
  logic                accept_c, shift_en_c, start_c;
  logic [WORD_W-1:0]   asm_word_c;
  logic                asm_last_c;

  logic                ready_d, wr_en_d, cpu_reset_d, busy_d, done_d, err_d;
  logic [31:0]         wr_addr_d, wr_instr_d;

  assign accept_c       = byte_valid_ldr_i && byte_ready_ldr_o;
  assign shift_en_c     = accept_c && ((state_q == HDR) || (state_q == DATA));
  assign start_c        = start_ldr_i && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign word_idx_inc_c = word_idx_q + WORD_W'(1);

  byte_word_asm u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_c),
    .shift_en  (shift_en_c),
    .data_byte (byte_ldr_i),
    .word_c    (asm_word_c),
    .last_c    (asm_last_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode for the frame parser.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start_ldr_i) state_d = HDR;
      HDR: begin
        if (shift_en_c && asm_last_c) begin
          if (asm_word_c > WORD_W'(IMEM_DEPTH_WORDS)) state_d = ERR;
          else if (asm_word_c == '0)                  state_d = CSUM;
          else                                        state_d = DATA;
        end
      end
      DATA:  if (shift_en_c && asm_last_c) state_d = WRITE;
      WRITE: state_d = (word_idx_inc_c == count_q) ? CSUM : DATA;
      CSUM: begin
        if (accept_c) state_d = (byte_ldr_i == xor_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the upcoming state, registered below.
  always_comb begin
    ready_d     = (state_d == HDR) || (state_d == DATA) || (state_d == CSUM);
    wr_en_d     = (state_d == WRITE);
    busy_d      = (state_d == HDR) || (state_d == DATA) || (state_d == WRITE) || (state_d == CSUM);
    done_d      = (state_d == DONE);
    err_d       = (state_d == ERR);
    cpu_reset_d = (state_d != DONE);
    wr_addr_d   = wr_addr_imem_ldr_o;
    wr_instr_d  = wr_instr_imem_ldr_o;
    if (state_d == WRITE) begin
      wr_addr_d  = BASE_ADDR + (word_idx_q << 2);
      wr_instr_d = asm_word_c;
    end
  end

  // Output registers plus count, word index and running checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_ready_ldr_o    <= 1'b0;
      wr_en_imem_ldr_o    <= 1'b0;
      wr_addr_imem_ldr_o  <= BASE_ADDR;
      wr_instr_imem_ldr_o <= '0;
      cpu_reset_ldr_o     <= 1'b1;
      busy_ldr_o          <= 1'b0;
      done_ldr_o          <= 1'b0;
      err_ldr_o           <= 1'b0;
      count_q             <= '0;
      word_idx_q          <= '0;
      xor_q               <= '0;
    end else begin
      byte_ready_ldr_o    <= ready_d;
      wr_en_imem_ldr_o    <= wr_en_d;
      wr_addr_imem_ldr_o  <= wr_addr_d;
      wr_instr_imem_ldr_o <= wr_instr_d;
      cpu_reset_ldr_o     <= cpu_reset_d;
      busy_ldr_o          <= busy_d;
      done_ldr_o          <= done_d;
      err_ldr_o           <= err_d;
      if (start_c) begin
        count_q    <= '0;
        word_idx_q <= '0;
        xor_q      <= '0;
      end else begin
        if (shift_en_c)                                     xor_q      <= xor_q ^ byte_ldr_i;
        if ((state_q == HDR) && shift_en_c && asm_last_c)   count_q    <= asm_word_c;
        if (state_q == WRITE)                               word_idx_q <= word_idx_inc_c;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader.
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned DEPTH = 1024;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        start_ldr_i;
  logic [7:0]  byte_ldr_i;
  logic        byte_valid_ldr_i;
  logic        byte_ready_ldr_o;
  logic [31:0] wr_addr_imem_ldr_o;
  logic [31:0] wr_instr_imem_ldr_o;
  logic        wr_en_imem_ldr_o;
  logic        cpu_reset_ldr_o;
  logic        busy_ldr_o;
  logic        done_ldr_o;
  logic        err_ldr_o;

  int  n_cmp = 0;
  int  n_bad = 0;
  wr_t exp_q[$];

  imem_loader #(.BASE_ADDR(BASE), .IMEM_DEPTH_WORDS(DEPTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start_ldr_i         (start_ldr_i),
    .byte_ldr_i          (byte_ldr_i),
    .byte_valid_ldr_i    (byte_valid_ldr_i),
    .byte_ready_ldr_o    (byte_ready_ldr_o),
    .wr_addr_imem_ldr_o  (wr_addr_imem_ldr_o),
    .wr_instr_imem_ldr_o (wr_instr_imem_ldr_o),
    .wr_en_imem_ldr_o    (wr_en_imem_ldr_o),
    .cpu_reset_ldr_o     (cpu_reset_ldr_o),
    .busy_ldr_o          (busy_ldr_o),
    .done_ldr_o          (done_ldr_o),
    .err_ldr_o           (err_ldr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (!reset && wr_en_imem_ldr_o) begin
      chk1("ready_during_write", byte_ready_ldr_o, 1'b0);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr %h instr %h want none", wr_addr_imem_ldr_o, wr_instr_imem_ldr_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_addr_imem_ldr_o !== e.a || wr_instr_imem_ldr_o !== e.d) begin
          n_bad++;
          $display("FAIL write: got addr %h instr %h want addr %h instr %h",
                   wr_addr_imem_ldr_o, wr_instr_imem_ldr_o, e.a, e.d);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk1({tag, "_ready"},     byte_ready_ldr_o, 1'b0);
    chk1({tag, "_wr_en"},     wr_en_imem_ldr_o, 1'b0);
    chk ({tag, "_addr"},      wr_addr_imem_ldr_o, BASE);
    chk ({tag, "_instr"},     wr_instr_imem_ldr_o, 32'h0);
    chk1({tag, "_cpu_reset"}, cpu_reset_ldr_o, 1'b1);
    chk1({tag, "_busy"},      busy_ldr_o, 1'b0);
    chk1({tag, "_done"},      done_ldr_o, 1'b0);
    chk1({tag, "_err"},       err_ldr_o, 1'b0);
  endtask

  // Present one byte with an optional random gap; returns once it is accepted.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int waited;
    waited = 0;
    ok = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      byte_valid_ldr_i = 1'b0;
      byte_ldr_i = 8'($urandom);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    byte_ldr_i = b;
    byte_valid_ldr_i = 1'b1;
    while (!ok && waited < 50) begin
      if (byte_ready_ldr_o) ok = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    byte_valid_ldr_i = 1'b0;
  endtask

  function automatic bq_t make_frame(input int unsigned n, input bit good);
    bq_t q;
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] nn;
    x  = 8'h00;
    nn = n;
    for (int i = 0; i < 4; i++) begin
      b = nn[31 - 8*i -: 8];
      q.push_back(b);
      x ^= b;
    end
    if (n <= DEPTH) begin
      for (int i = 0; i < 4 * int'(n); i++) begin
        b = 8'($urandom);
        q.push_back(b);
        x ^= b;
      end
      q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    end
    return q;
  endfunction

  // Reference: parse the frame, queue the writes, then drive it and check the outcome.
  task automatic run_frame(input bq_t fr, input bit poke);
    logic [31:0] n;
    logic [7:0]  x;
    int          acc;
    bit          exp_done;
    bit          ok;
    wr_t         w;
    n = {fr[0], fr[1], fr[2], fr[3]};
    x = 8'h00;
    if (n > DEPTH) begin
      acc = 4;
      exp_done = 1'b0;
    end else begin
      acc = 5 + 4 * int'(n);
      for (int k = 0; k < int'(n); k++) begin
        w.a = BASE + 32'(4 * k);
        w.d = {fr[4 + 4*k], fr[5 + 4*k], fr[6 + 4*k], fr[7 + 4*k]};
        exp_q.push_back(w);
      end
      for (int i = 0; i < acc - 1; i++) x ^= fr[i];
      exp_done = (fr[acc - 1] == x);
    end
    start_ldr_i = 1'b1;
    @(posedge clk);
    #1;
    start_ldr_i = 1'b0;
    chk1("busy_after_start", busy_ldr_o, 1'b1);
    chk1("cpu_reset_after_start", cpu_reset_ldr_o, 1'b1);
    for (int i = 0; i < acc; i++) begin
      send_byte(fr[i], ok);
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL byte_timeout: got no ready want accept of byte %0d", i);
        return;
      end
      if (poke && i == 1) begin
        start_ldr_i = 1'b1;
        @(posedge clk);
        #1;
        start_ldr_i = 1'b0;
      end
    end
    chk1("done", done_ldr_o, exp_done);
    chk1("err", err_ldr_o, !exp_done);
    chk1("cpu_reset_end", cpu_reset_ldr_o, !exp_done);
    chk1("busy_end", busy_ldr_o, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk1("ready_idle_end", byte_ready_ldr_o, 1'b0);
    chk1("done_sticky", done_ldr_o, exp_done);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bq_t fr;
    bq_t two;
    bit  ok;
    reset = 1'b1;
    start_ldr_i = 1'b0;
    byte_valid_ldr_i = 1'b0;
    byte_ldr_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    two = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h2F};
    run_frame(two, 1'b0);

    fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fr, 1'b0);

    fr = '{8'h00, 8'h00, 8'h04, 8'h01};
    run_frame(fr, 1'b0);

    fr = two;
    fr[12] = 8'h30;
    run_frame(fr, 1'b1);

    for (int t = 0; t < 10; t++) begin
      fr = make_frame($urandom_range(0, 6), ($urandom_range(0, 3) != 0));
      run_frame(fr, t[0]);
    end

    fr = make_frame(DEPTH, 1'b1);
    run_frame(fr, 1'b0);

    start_ldr_i = 1'b1;
    @(posedge clk);
    #1;
    start_ldr_i = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(two[i], ok);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("midload_reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_frame(two, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The fetch stage only reads instruction memory; this block fills it.
- Receives a framed byte stream over a valid/ready handshake, for example from a UART receiver or a debug port.
- Assembles big-endian 32-bit instruction words and writes them sequentially into instruction memory.
- Holds the CPU core in reset until the image has loaded and its checksum has verified.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written.
- IMEM_DEPTH_WORDS, 1024, instruction memory capacity in words. Larger image counts are rejected.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start_ldr_i  input  1  one-cycle pulse that begins a load; honoured in IDLE, DONE and ERR.
- byte_ldr_i  input  8  stream byte.
- byte_valid_ldr_i  input  1  byte_ldr_i is valid.
- byte_ready_ldr_o  output  1  loader accepts a byte this cycle.
- wr_addr_imem_ldr_o  output  32  imem byte address for the write.
- wr_instr_imem_ldr_o  output  32  instruction word to write.
- wr_en_imem_ldr_o  output  1  one-cycle imem write strobe.
- cpu_reset_ldr_o  output  1  reset to the CPU core; high until a successful load.
- busy_ldr_o  output  1  a load is in progress.
- done_ldr_o  output  1  load completed and checksum matched (sticky).
- err_ldr_o  output  1  load failed (sticky).

Behaviour:
- Frame format:
  - 4 header bytes carrying word count N, MSB first.
  - N×4 data bytes, each word MSB first.
  - 1 checksum byte equal to the XOR of all header and data bytes.
- Handshake:
  - A byte transfers on a rising clk when byte_valid_ldr_i && byte_ready_ldr_o.
  - byte_ready_ldr_o is high only in HDR, DATA and CSUM.
  - Upstream holds the byte stable while ready is low.
- All outputs are registered.
- Reset values:
  - byte_ready_ldr_o=0, wr_en_imem_ldr_o=0, wr_addr_imem_ldr_o=BASE_ADDR, wr_instr_imem_ldr_o=0.
  - cpu_reset_ldr_o=1, busy_ldr_o=0, done_ldr_o=0, err_ldr_o=0.
  - State=IDLE, internal byte index=0, word index=0, running XOR=0.
- States:
  - IDLE: cpu_reset=1. On start_ldr_i, go to HDR, clear the index, XOR and done/err, set busy.
  - HDR: accept 4 bytes into the count, MSB first. After the 4th byte:
    - N > IMEM_DEPTH_WORDS: go to ERR.
    - N == 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA: accept 4 bytes into the word shift register. After the 4th byte go to WRITE.
  - WRITE: exactly one cycle.
    - wr_en=1, addr=BASE_ADDR + 4×word_index (mod 2^32), instr=assembled word, ready=0.
    - Then increment word_index. If it equals N go to CSUM, else go to DATA.
  - CSUM: accept 1 byte.
    - Byte equals running XOR: go to DONE.
    - Otherwise: go to ERR.
  - DONE: done=1, busy=0, cpu_reset=0.
  - ERR: err=1, busy=0, cpu_reset=1.
- DONE and ERR remain until start_ldr_i or reset. start_ldr_i in DONE reasserts cpu_reset the next cycle.
- start_ldr_i while busy is ignored.
- The running XOR includes every accepted header and data byte, but not the checksum byte.
- Latency: wr_en pulses in the cycle after the 4th data byte of a word is accepted. Minimum 5 cycles per word.
- Reset mid-load returns to IDLE with reset values. Words already written are not undone.
- wr_en_imem_ldr_o never asserts outside WRITE.

Decomposition:
- Shared package `imem_loader_pkg`:
  - State enum: IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR.
  - Constants: HDR_BYTES=4, WORD_BYTES=4.
- Optional sub-module `byte_word_asm`: a 4-byte MSB-first shift assembler with a byte counter and last-byte flag, reused for both the header count and the data words.
- Everything else stays in imem_loader.

Test Plan:
- Two-word load:
  - Stimulus: start; bytes 00 00 00 02, 20 08 00 05, 00 00 00 00, 2F.
  - Response: two wr_en pulses, (0x0, 0x20080005) then (0x4, 0x00000000); done=1, cpu_reset=0, err=0.
- Empty image:
  - Stimulus: start; bytes 00 00 00 00 00.
  - Response: no wr_en; done=1 the cycle after the checksum byte is accepted.
- Overflow:
  - Stimulus: header 00 00 04 01 with depth 1024.
  - Response: ERR after the 4th header byte; no wr_en; ready=0; cpu_reset stays 1.
- Bad checksum:
  - Stimulus: the two-word frame with checksum 30.
  - Response: both words are written; then err=1, done=0, cpu_reset=1.
- Backpressure and gaps:
  - Stimulus: byte_valid toggled randomly, with valid held high across WRITE cycles.
  - Response: no byte is lost or duplicated; ready=0 during WRITE; write contents match the two-word test.
- Reset and restart:
  - Stimulus: reset asserted after 6 bytes, then start and a full two-word frame.
  - Response: all outputs return to reset values; the second load completes with done=1 and addresses starting at BASE_ADDR.
